// File: rtl/wb_store_buffer.sv
// wb_store_buffer: writeback-to-dcache store FIFO with tail write-combining and load conflict detection
module wb_store_buffer #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int COALESCE = 1,
    localparam int BM_W = DATA_W / 8,
    localparam int OFS = $clog2(BM_W),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              WB_V,
    input  logic              WB_Dcache_Write,
    input  logic [ADDR_W-1:0] WB_Dcache_Address,
    input  logic [DATA_W-1:0] WB_Dcache_Data,
    input  logic [BM_W-1:0]   WB_Dcache_Bmask,
    output logic              wb_stall,
    output logic              DC_Write,
    output logic [ADDR_W-1:0] DC_Address,
    output logic [DATA_W-1:0] DC_Data,
    output logic [BM_W-1:0]   DC_Bmask,
    input  logic              In_write_ready,
    input  logic [ADDR_W-1:0] LD_Probe_Address,
    output logic              LD_Conflict,
    output logic              SB_Empty,
    output logic [CNT_W-1:0]  SB_Count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LMASK = ~((ADDR_W'(1) << OFS) - ADDR_W'(1));

    logic [ADDR_W-1:0] line_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BM_W-1:0]   bm_q   [DEPTH];
    logic [PW-1:0]     head, tail, prev;
    logic [CNT_W-1:0]  count;
    logic              enq_req, coal, full, enq, deq;
    logic [ADDR_W-1:0] wline, pline;
    logic [DATA_W-1:0] mdata;
    logic [DEPTH-1:0]  hit;

    for (genvar g = 0; g < DEPTH; g++) begin : hit_g
        assign hit[g] = ({1'b0, PW'(g) - head} < count) && (line_q[g] == pline);
    end

    for (genvar g = 0; g < BM_W; g++) begin : byte_g
        assign mdata[8*g +: 8] = WB_Dcache_Bmask[g] ? WB_Dcache_Data[8*g +: 8] : data_q[prev][8*g +: 8];
    end

    // Request decode, coalesce/stall decisions, head presentation and conflict probe
    always_comb begin
        wline = WB_Dcache_Address & LMASK;
        pline = LD_Probe_Address & LMASK;
        prev = tail - PW'(1);
        enq_req = WB_V & WB_Dcache_Write;
        full = count == CNT_W'(DEPTH);
        coal = (COALESCE != 0) && enq_req && (count >= CNT_W'(2)) && (line_q[prev] == wline);
        enq = enq_req & ~coal & ~full;
        wb_stall = enq_req & ~coal & full;
        DC_Write = count != '0;
        deq = DC_Write & In_write_ready;
        DC_Address = line_q[head];
        DC_Data = data_q[head];
        DC_Bmask = bm_q[head];
        LD_Conflict = (|hit) | (enq_req & ~wb_stall & (wline == pline));
        SB_Empty = count == '0;
        SB_Count = count;
    end

    // Pointer and occupancy bookkeeping; reset discards all buffered stores
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Entry storage: new stores land at tail, combining stores merge bytes into the newest entry
    always_ff @(posedge CLK) begin
        if (enq) begin
            line_q[tail] <= wline;
            data_q[tail] <= WB_Dcache_Data;
            bm_q[tail] <= WB_Dcache_Bmask;
        end
        if (coal) begin
            data_q[prev] <= mdata;
            bm_q[prev] <= bm_q[prev] | WB_Dcache_Bmask;
        end
    end
endmodule

// File: tb/tb_wb_store_buffer.sv
// tb_wb_store_buffer: directed vector table plus randomized run against a queue model of the store buffer
module tb_wb_store_buffer;
    logic        CLK = 0;
    logic        CLR = 0;
    logic        WB_V = 0, WB_Dcache_Write = 0, In_write_ready = 0;
    logic [31:0] WB_Dcache_Address = 0, LD_Probe_Address = 0;
    logic [63:0] WB_Dcache_Data = 0;
    logic [7:0]  WB_Dcache_Bmask = 0;
    logic        wb_stall, DC_Write, LD_Conflict, SB_Empty;
    logic [31:0] DC_Address;
    logic [63:0] DC_Data;
    logic [7:0]  DC_Bmask;
    logic [2:0]  SB_Count;
    logic        n_stall, n_dcw, n_conf, n_empty;
    logic [31:0] n_addr;
    logic [63:0] n_data;
    logic [7:0]  n_bm;
    logic [2:0]  n_cnt;

    int n_vec = 0;
    int n_err = 0;

    wb_store_buffer #(.DEPTH(4), .DATA_W(64), .ADDR_W(32), .COALESCE(1)) dut (
        .CLK(CLK), .CLR(CLR), .WB_V(WB_V), .WB_Dcache_Write(WB_Dcache_Write),
        .WB_Dcache_Address(WB_Dcache_Address), .WB_Dcache_Data(WB_Dcache_Data),
        .WB_Dcache_Bmask(WB_Dcache_Bmask), .wb_stall(wb_stall), .DC_Write(DC_Write),
        .DC_Address(DC_Address), .DC_Data(DC_Data), .DC_Bmask(DC_Bmask),
        .In_write_ready(In_write_ready), .LD_Probe_Address(LD_Probe_Address),
        .LD_Conflict(LD_Conflict), .SB_Empty(SB_Empty), .SB_Count(SB_Count)
    );

    wb_store_buffer #(.DEPTH(4), .DATA_W(64), .ADDR_W(32), .COALESCE(0)) dut_nc (
        .CLK(CLK), .CLR(CLR), .WB_V(WB_V), .WB_Dcache_Write(WB_Dcache_Write),
        .WB_Dcache_Address(WB_Dcache_Address), .WB_Dcache_Data(WB_Dcache_Data),
        .WB_Dcache_Bmask(WB_Dcache_Bmask), .wb_stall(n_stall), .DC_Write(n_dcw),
        .DC_Address(n_addr), .DC_Data(n_data), .DC_Bmask(n_bm),
        .In_write_ready(In_write_ready), .LD_Probe_Address(LD_Probe_Address),
        .LD_Conflict(n_conf), .SB_Empty(n_empty), .SB_Count(n_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] line;
        logic [63:0] data;
        logic [7:0]  bm;
    } ent_t;
    ent_t q[$];

    typedef struct {
        bit          v;
        logic [31:0] addr;
        logic [7:0]  bm;
        bit          rdy;
        logic [31:0] probe;
        bit          stall;
        bit          stall_nc;
        bit          dcw;
        logic [31:0] dca;
        logic [7:0]  dcbm;
        int          cnt;
        bit          conf;
    } vec_t;
    vec_t tbl[37];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of the reference model: check outputs against the queue, then commit the edge
    task automatic cycle();
        logic [31:0] wl, pl;
        logic        enq_req, coal, stall, conf;
        int          n;
        #1;
        n = q.size();
        wl = WB_Dcache_Address & ~32'h7;
        pl = LD_Probe_Address & ~32'h7;
        enq_req = WB_V & WB_Dcache_Write;
        coal = 0;
        if (enq_req && n >= 2) coal = q[n-1].line == wl;
        stall = enq_req && !coal && n == 4;
        conf = enq_req && !stall && wl == pl;
        foreach (q[i]) if (q[i].line == pl) conf = 1;
        chk("m_stall", wb_stall, stall);
        chk("m_dc_write", DC_Write, n != 0);
        chk("m_count", SB_Count, n);
        chk("m_empty", SB_Empty, n == 0);
        chk("m_conflict", LD_Conflict, conf);
        if (n != 0) begin
            chk("m_dc_addr", DC_Address, q[0].line);
            chk("m_dc_data", DC_Data, q[0].data);
            chk("m_dc_bmask", DC_Bmask, q[0].bm);
        end
        @(posedge CLK);
        if (coal)
            for (int b = 0; b < 8; b++)
                if (WB_Dcache_Bmask[b]) begin
                    q[n-1].data[8*b +: 8] = WB_Dcache_Data[8*b +: 8];
                    q[n-1].bm[b] = 1'b1;
                end
        if (n != 0 && In_write_ready) void'(q.pop_front());
        if (enq_req && !coal && !stall) q.push_back('{wl, WB_Dcache_Data, WB_Dcache_Bmask});
        @(negedge CLK);
    endtask

    localparam logic [31:0] P = 32'hFFF0;

    initial begin
        // v, addr, bm, rdy, probe, stall, stall_nc, dcw, dca, dcbm, cnt, conf
        tbl[0]  = '{1, 32'h1004, 8'h10, 1, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[1]  = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h1000, 8'h10, 1, 0};
        tbl[2]  = '{0, 32'h0, 8'h00, 1, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[3]  = '{1, 32'h00, 8'hFF, 0, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[4]  = '{1, 32'h08, 8'hFF, 0, P, 0, 0, 1, 32'h00, 8'hFF, 1, 0};
        tbl[5]  = '{1, 32'h10, 8'hFF, 0, P, 0, 0, 1, 32'h00, 8'hFF, 2, 0};
        tbl[6]  = '{1, 32'h18, 8'hFF, 0, P, 0, 0, 1, 32'h00, 8'hFF, 3, 0};
        tbl[7]  = '{1, 32'h20, 8'hFF, 0, P, 1, 1, 1, 32'h00, 8'hFF, 4, 0};
        tbl[8]  = '{1, 32'h20, 8'hFF, 1, P, 1, 1, 1, 32'h00, 8'hFF, 4, 0};
        tbl[9]  = '{1, 32'h20, 8'hFF, 1, P, 0, 0, 1, 32'h08, 8'hFF, 3, 0};
        tbl[10] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h10, 8'hFF, 3, 0};
        tbl[11] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h18, 8'hFF, 2, 0};
        tbl[12] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h20, 8'hFF, 1, 0};
        tbl[13] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[14] = '{1, 32'h100, 8'hFF, 0, 32'h104, 0, 0, 0, 32'h0, 8'h00, 0, 1};
        tbl[15] = '{0, 32'h0, 8'h00, 0, 32'h104, 0, 0, 1, 32'h100, 8'hFF, 1, 1};
        tbl[16] = '{0, 32'h0, 8'h00, 0, 32'h108, 0, 0, 1, 32'h100, 8'hFF, 1, 0};
        tbl[17] = '{1, 32'h200, 8'hFF, 0, 32'h200, 0, 0, 1, 32'h100, 8'hFF, 1, 1};
        tbl[18] = '{1, 32'h208, 8'hFF, 0, P, 0, 0, 1, 32'h100, 8'hFF, 2, 0};
        tbl[19] = '{1, 32'h210, 8'hFF, 0, P, 0, 0, 1, 32'h100, 8'hFF, 3, 0};
        tbl[20] = '{1, 32'h300, 8'hFF, 0, 32'h300, 1, 1, 1, 32'h100, 8'hFF, 4, 0};
        tbl[21] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h100, 8'hFF, 4, 0};
        tbl[22] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h200, 8'hFF, 3, 0};
        tbl[23] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h208, 8'hFF, 2, 0};
        tbl[24] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h210, 8'hFF, 1, 0};
        tbl[25] = '{0, 32'h0, 8'h00, 0, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[26] = '{1, 32'h40, 8'h01, 0, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};
        tbl[27] = '{1, 32'h40, 8'h02, 0, P, 0, 0, 1, 32'h40, 8'h01, 1, 0};
        tbl[28] = '{0, 32'h0, 8'h00, 0, P, 0, 0, 1, 32'h40, 8'h01, 2, 0};
        tbl[29] = '{1, 32'h48, 8'hFF, 0, P, 0, 0, 1, 32'h40, 8'h01, 2, 0};
        tbl[30] = '{1, 32'h80, 8'h01, 0, P, 0, 0, 1, 32'h40, 8'h01, 3, 0};
        tbl[31] = '{1, 32'h80, 8'h02, 0, P, 0, 1, 1, 32'h40, 8'h01, 4, 0};
        tbl[32] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h40, 8'h01, 4, 0};
        tbl[33] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h40, 8'h02, 3, 0};
        tbl[34] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h48, 8'hFF, 2, 0};
        tbl[35] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 1, 32'h80, 8'h03, 1, 0};
        tbl[36] = '{0, 32'h0, 8'h00, 1, P, 0, 0, 0, 32'h0, 8'h00, 0, 0};

        LD_Probe_Address = P;
        #2 CLR = 1;
        #1;
        chk("rst_dc_write", DC_Write, 0);
        chk("rst_count", SB_Count, 0);
        chk("rst_empty", SB_Empty, 1);
        chk("rst_stall", wb_stall, 0);
        chk("rst_conflict", LD_Conflict, 0);
        @(negedge CLK);
        CLR = 0;

        for (int i = 0; i < 37; i++) begin
            WB_V = tbl[i].v;
            WB_Dcache_Write = tbl[i].v;
            WB_Dcache_Address = tbl[i].addr;
            WB_Dcache_Data = (i == 0) ? 64'h000000AA_00000000 : {$urandom, $urandom};
            WB_Dcache_Bmask = tbl[i].bm;
            In_write_ready = tbl[i].rdy;
            LD_Probe_Address = tbl[i].probe;
            #1;
            chk($sformatf("r%0d_stall", i), wb_stall, tbl[i].stall);
            chk($sformatf("r%0d_stall_nocoal", i), n_stall, tbl[i].stall_nc);
            chk($sformatf("r%0d_dc_write", i), DC_Write, tbl[i].dcw);
            chk($sformatf("r%0d_count", i), SB_Count, tbl[i].cnt);
            chk($sformatf("r%0d_conflict", i), LD_Conflict, tbl[i].conf);
            if (tbl[i].dcw) begin
                chk($sformatf("r%0d_dc_addr", i), DC_Address, tbl[i].dca);
                chk($sformatf("r%0d_dc_bmask", i), DC_Bmask, tbl[i].dcbm);
            end
            cycle();
        end

        WB_V = 1;
        WB_Dcache_Write = 1;
        In_write_ready = 0;
        LD_Probe_Address = P;
        for (int i = 0; i < 2; i++) begin
            WB_Dcache_Address = 32'h500 + 32'(i * 8);
            WB_Dcache_Data = {$urandom, $urandom};
            WB_Dcache_Bmask = 8'hFF;
            cycle();
        end
        WB_V = 0;
        WB_Dcache_Write = 0;
        In_write_ready = 1;
        #2 CLR = 1;
        #1;
        chk("mid_rst_dc_write", DC_Write, 0);
        chk("mid_rst_count", SB_Count, 0);
        chk("mid_rst_empty", SB_Empty, 1);
        q.delete();
        @(negedge CLK);
        CLR = 0;

        for (int i = 0; i < 3000; i++) begin
            WB_V = $urandom_range(0, 3) != 0;
            WB_Dcache_Write = $urandom_range(0, 4) != 0;
            WB_Dcache_Address = 32'h400 + 32'($urandom_range(0, 5) << 3) + 32'($urandom_range(0, 7));
            WB_Dcache_Data = {$urandom, $urandom};
            WB_Dcache_Bmask = 8'($urandom);
            In_write_ready = $urandom_range(0, 2) == 0;
            LD_Probe_Address = 32'h400 + 32'($urandom_range(0, 7) << 3) + 32'($urandom_range(0, 7));
            cycle();
        end
        WB_V = 0;
        WB_Dcache_Write = 0;
        In_write_ready = 1;
        for (int i = 0; i < 6; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
